// File: rtl/comp_pkg.sv
// -----------------------------------------------------------------------------
// comp_pkg
// Shared definitions for the serial magnitude comparator:
//   - one-hot compare codes, indexed [0:2] = {lt, eq, gt}
//   - FSM state encoding for serial_mag_comp
// -----------------------------------------------------------------------------
package comp_pkg;

  localparam logic [0:2] CMP_LT   = 3'b100;
  localparam logic [0:2] CMP_EQ   = 3'b010;
  localparam logic [0:2] CMP_GT   = 3'b001;
  localparam logic [0:2] CMP_NONE = 3'b000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_mag_comp_if.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_if
// Framed bit-serial stream into the comparator and its result/status outputs.
//   in_start  frame start pulse (data not sampled that cycle)
//   in_valid  in_a/in_b/in_last valid
//   in_a/in_b operand bits, MSB first
//   in_last   final bit pair of the frame
//   out_y     registered one-hot result {lt, eq, gt}
//   out_done  one-cycle pulse, new result on out_y
//   out_err   one-cycle pulse, framing error
//   out_busy  frame in progress
// master: stream source / result consumer.  slave: the comparator.
// -----------------------------------------------------------------------------
interface serial_mag_comp_if;

  logic       in_start;
  logic       in_valid;
  logic       in_a;
  logic       in_b;
  logic       in_last;
  logic [0:2] out_y;
  logic       out_done;
  logic       out_err;
  logic       out_busy;

  modport master (
    output in_start, in_valid, in_a, in_b, in_last,
    input  out_y, out_done, out_err, out_busy
  );

  modport slave (
    input  in_start, in_valid, in_a, in_b, in_last,
    output out_y, out_done, out_err, out_busy
  );

endinterface

// File: rtl/serial_mag_comp_comp11.sv
// -----------------------------------------------------------------------------
// comp11
// Combinational 1-bit magnitude comparator.
//   a_i, b_i  operand bits
//   y_o       one-hot {lt, eq, gt}, indexed [0:2]
// -----------------------------------------------------------------------------
module comp11 (
  input  logic       a_i,
  input  logic       b_i,
  output logic [0:2] y_o
);

  assign y_o = {~a_i & b_i, a_i ~^ b_i, a_i & ~b_i};

endmodule

// File: rtl/serial_mag_comp.sv
// -----------------------------------------------------------------------------
// serial_mag_comp
// Bit-serial WIDTH-bit magnitude comparator. Consumes MSB-first (a,b) pairs
// framed by in_start/in_last; the first differing pair decides the result.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_mag_comp_if.slave (stream in, result/status out)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for in_start; in_valid ignored
//   ST_CMP  | frame in progress; sampling bit pairs on in_valid
// -----------------------------------------------------------------------------
module serial_mag_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_mag_comp_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:2]       res_q, res_d;
  logic             decided_q, decided_d;
  logic [0:2]       y_q, y_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [0:2]       bit_y;
  logic             last_pos;

  comp11 u_comp11 (
    .a_i (bus.in_a),
    .b_i (bus.in_b),
    .y_o (bit_y)
  );

  assign last_pos = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_q     <= CMP_NONE;
      decided_q <= 1'b0;
      y_q       <= CMP_NONE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      decided_q <= decided_d;
      y_q       <= y_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    decided_d = decided_q;
    y_d       = y_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          state_d   = ST_CMP;
          cnt_d     = '0;
          res_d     = CMP_EQ;
          decided_d = 1'b0;
        end
      end

      ST_CMP: begin
        if (bus.in_start) begin
          // restart discards the partial frame without any status pulse
          cnt_d     = '0;
          res_d     = CMP_EQ;
          decided_d = 1'b0;
        end else if (bus.in_valid) begin
          if (!decided_q && (bit_y != CMP_EQ)) begin
            res_d     = bit_y;
            decided_d = 1'b1;
          end
          // res_d already folds in the current pair, so the final bit counts
          if (bus.in_last && last_pos) begin
            state_d = ST_IDLE;
            y_d     = res_d;
            done_d  = 1'b1;
          end else if (bus.in_last || last_pos) begin
            state_d = ST_IDLE;
            y_d     = CMP_NONE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_y    = y_q;
  assign bus.out_done = done_q;
  assign bus.out_err  = err_q;
  assign bus.out_busy = (state_q == ST_CMP);

endmodule

// File: doc/serial_mag_comp.md
Name: serial_mag_comp

Overview:
- Bit-serial N-bit magnitude comparator that consumes MSB-first (a,b) bit pairs, one pair per accepted cycle.
- Produces the lab's standard one-hot compare code: index 0 = a<b, index 1 = a=b, index 2 = a>b.
- It is the upstream counterpart of the combinational 1-bit comparator. It accumulates the same per-bit result across a framed serial stream, so wide operands arriving from a shift-register source can be compared.

Parameters:
- WIDTH, 4, operand length in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_start  in  1  frame start pulse; bit data is not sampled on this cycle.
- in_valid  in  1  in_a/in_b/in_last are valid this cycle.
- in_a  in  1  serial operand A bit, MSB first.
- in_b  in  1  serial operand B bit, MSB first.
- in_last  in  1  marks the final bit pair of the frame.
- out_y  out  [0:2]  registered one-hot result {lt, eq, gt}.
- out_done  out  1  one-cycle pulse: out_y updated with a new result.
- out_err  out  1  one-cycle pulse: framing error, frame discarded.
- out_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, out_y=3'b000, out_done=0, out_err=0, out_busy=0, cnt=0, internal decided flags cleared.
- States:
  - IDLE: in_valid is ignored. in_start -> CMP, cnt=0, decided=0, res=EQ (3'b010).
  - CMP: out_busy=1. Each cycle with in_valid=1, one bit pair is sampled and cnt increments.
- Per-bit rule in CMP, while not decided:
  - in_a<in_b -> res=LT, decided=1.
  - in_a>in_b -> res=GT, decided=1.
  - equal bits -> res stays EQ.
  - Once decided=1, later bits are counted but do not alter res. The first differing bit from the MSB wins.
- Frame completion: a sampled pair with cnt==WIDTH-1 and in_last=1 returns to IDLE. On the next edge, out_y=final res and out_done=1 for exactly one cycle. Latency is one clock from the last sampled bit to out_done.
- Framing errors: each one causes IDLE, an out_err=1 pulse for one cycle, and out_y forced to 3'b000.
  - in_last=1 with cnt<WIDTH-1 (short frame).
  - cnt==WIDTH-1 sampled with in_last=0 (long frame).
- in_start while in CMP: the current frame is silently restarted (cnt=0, res=EQ, decided=0). No done, no err.
- in_start and in_valid in the same cycle: in_start wins and data is not sampled.
- in_valid=0 cycles in CMP are stalls. State, cnt and res are held, with no timeout.
- out_done and out_err are never high together. out_y is always 3'b000 or exactly one-hot.
- out_y holds its value between frames and changes only on done, err or reset.
- rst_n low mid-frame: everything returns to reset values immediately. No done or err is emitted.

Decomposition:
- Shared package comp_pkg holds the one-hot localparams CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001 and CMP_NONE=3'b000. Bit indices use the [0:2] ordering. The state encodings ST_IDLE and ST_CMP also live there.
- The per-bit decision reuses the existing 1-bit comparator as a single instantiated sub-module (comp11). The FSM only gates its output with in_valid and decided.

Test Plan:
1. Reset values: hold rst_n=0 for 2 cycles -> out_y=000, out_done=0, out_err=0, out_busy=0. Drive in_valid toggling in IDLE -> no change.
2. Basic results (WIDTH=4):
   - A=1010, B=1001 -> out_done pulse one cycle after bit 3, out_y=001 (gt).
   - A=0111, B=1000 -> out_y=100 (lt).
   - A=B=0110 -> out_y=010 (eq).
3. Stalls: A=0011, B=0101 with in_valid low for 3 cycles between bits 1 and 2 -> out_y=100, done pulse exactly once, out_busy high throughout the frame.
4. Framing errors:
   - in_last on bit 2 of 4 -> out_err pulse, out_y=000, no done.
   - Bit 3 sampled without in_last -> out_err pulse.
5. Restart: in_start after 2 bits, then full frame A=1100, B=1100 -> single done, out_y=010. The pre-restart bits have no effect.
6. Reset mid-frame: assert rst_n=0 after bit 1 -> outputs reset asynchronously. A subsequent frame A=0001, B=0000 -> out_y=001.
